// File: rtl/sram_arbiter.sv
// sram_arbiter: two-requester round-robin sequencer in front of an
// 8x8 single-port SRAM with registered (1-cycle) read.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   reqN_valid/ready    command handshake for requester N (0/1)
//   reqN_wr/addr/wdata  command: 1=write, word address, write data
//   rspN_valid          one-cycle response pulse (write ack / read data)
//   rspN_rdata          last read data returned to requester N
//   mem_wr/rd/add       registered SRAM strobes and address
//   mem_data_in         registered SRAM write data
//   mem_data_out        SRAM read data (high-Z except the cycle after rd)
module sram_arbiter #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 3,
    parameter bit PRIO_RESET = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_wr,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_wr,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_add,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        RESP
    } state_t;

    state_t state;
    state_t state_nxt;

    logic prio;
    logic owner;
    logic op_wr;
    logic grant;
    logic hs;

    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Ready is gated by rst so nothing is accepted while in reset.
    always_comb begin
        grant = prio;
        if (req0_valid && !req1_valid) begin
            grant = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            grant = 1'b1;
        end

        req0_ready = (state == IDLE) && !rst
                     && req0_valid && !grant;
        req1_ready = (state == IDLE) && !rst
                     && req1_valid && grant;
        hs = req0_ready || req1_ready;

        sel_wr    = grant ? req1_wr    : req0_wr;
        sel_addr  = grant ? req1_addr  : req0_addr;
        sel_wdata = grant ? req1_wdata : req0_wdata;

        state_nxt = state;
        unique case (state)
            IDLE:    if (hs) state_nxt = ISSUE;
            ISSUE:   state_nxt = op_wr ? RESP : CAPTURE;
            CAPTURE: state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Strobes are set on the handshake edge so they are high exactly
    // during the ISSUE cycle; read data is sampled only in CAPTURE,
    // the one cycle the SRAM is actually driving its output.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio        <= PRIO_RESET;
            owner       <= 1'b0;
            op_wr       <= 1'b0;
            mem_wr      <= 1'b0;
            mem_rd      <= 1'b0;
            mem_add     <= '0;
            mem_data_in <= '0;
            rsp0_valid  <= 1'b0;
            rsp1_valid  <= 1'b0;
            rsp0_rdata  <= '0;
            rsp1_rdata  <= '0;
        end else begin
            mem_wr     <= 1'b0;
            mem_rd     <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;

            if (hs) begin
                owner       <= grant;
                prio        <= ~grant;
                op_wr       <= sel_wr;
                mem_add     <= sel_addr;
                mem_data_in <= sel_wdata;
                mem_wr      <= sel_wr;
                mem_rd      <= ~sel_wr;
            end

            if (state == ISSUE && op_wr) begin
                rsp0_valid <= ~owner;
                rsp1_valid <= owner;
            end

            if (state == CAPTURE) begin
                rsp0_valid <= ~owner;
                rsp1_valid <= owner;
                if (owner) begin
                    rsp1_rdata <= mem_data_out;
                end else begin
                    rsp0_rdata <= mem_data_out;
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: randomized and directed stimulus for sram_arbiter,
// checked cycle by cycle against a transaction-level model.
module tb_sram_arbiter;

    localparam bit PRIO_RESET = 1'b0;

    logic       clk;
    logic       rst;
    logic       req0_valid, req0_ready, req0_wr;
    logic [2:0] req0_addr;
    logic [7:0] req0_wdata;
    logic       rsp0_valid;
    logic [7:0] rsp0_rdata;
    logic       req1_valid, req1_ready, req1_wr;
    logic [2:0] req1_addr;
    logic [7:0] req1_wdata;
    logic       rsp1_valid;
    logic [7:0] rsp1_rdata;
    logic       mem_wr, mem_rd;
    logic [2:0] mem_add;
    logic [7:0] mem_data_in;
    wire  [7:0] mem_data_out;

    sram_arbiter #(
        .DATA_W(8), .ADDR_W(3), .PRIO_RESET(PRIO_RESET)
    ) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_wr(req0_wr), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_wr(req1_wr), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_add(mem_add),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM: registered read, output floats except the cycle after rd.
    logic [7:0] sram [8];
    logic [7:0] dq;
    logic       dv = 1'b0;
    always @(posedge clk) begin
        if (mem_wr) sram[mem_add] <= mem_data_in;
        if (mem_rd) dq <= sram[mem_add];
        dv <= mem_rd;
    end
    assign mem_data_out = dv ? dq : 8'bz;

    typedef struct {
        logic       wr;
        logic [2:0] addr;
        logic [7:0] data;
    } cmd_t;

    cmd_t q0[$];
    cmd_t q1[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Transaction-level model state.
    logic [7:0] ref_mem [8];
    logic [7:0] exp_rdata [2];
    logic       m_prio;
    logic       p_valid;
    int         p_cyc;
    logic       p_owner;
    logic       p_wr;
    logic [2:0] p_addr;
    logic [7:0] p_data;

    int  rst_cnt;
    bit  force_both;
    bit  arm;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h",
                     tag, cyc, got, exp);
        end
    endtask

    task automatic push(input int who, input logic wr,
                        input logic [2:0] a, input logic [7:0] d);
        cmd_t c;
        c.wr = wr; c.addr = a; c.data = d;
        if (who == 0) q0.push_back(c);
        else q1.push_back(c);
    endtask

    task automatic model_check();
        logic e_wr, e_rd, e_r0, e_r1, e_rsp;
        int   lat;
        int   g;
        lat   = p_wr ? 2 : 3;
        e_wr  = p_valid && p_wr && cyc == p_cyc + 1;
        e_rd  = p_valid && !p_wr && cyc == p_cyc + 1;
        e_rsp = p_valid && cyc == p_cyc + lat;
        e_r0  = e_rsp && !p_owner;
        e_r1  = e_rsp && p_owner;

        chk("mem_wr", {31'd0, mem_wr}, {31'd0, e_wr});
        chk("mem_rd", {31'd0, mem_rd}, {31'd0, e_rd});
        if (e_wr || e_rd)
            chk("mem_add", {29'd0, mem_add}, {29'd0, p_addr});
        if (e_wr)
            chk("mem_data_in", {24'd0, mem_data_in},
                {24'd0, p_data});

        if (e_rsp && !p_wr) exp_rdata[p_owner] = p_data;
        chk("rsp0_valid", {31'd0, rsp0_valid}, {31'd0, e_r0});
        chk("rsp1_valid", {31'd0, rsp1_valid}, {31'd0, e_r1});
        chk("rsp0_rdata", {24'd0, rsp0_rdata},
            {24'd0, exp_rdata[0]});
        chk("rsp1_rdata", {24'd0, rsp1_rdata},
            {24'd0, exp_rdata[1]});

        g = -1;
        if (!rst && !p_valid) begin
            if (req0_valid && req1_valid) g = int'(m_prio);
            else if (req0_valid) g = 0;
            else if (req1_valid) g = 1;
        end
        chk("req0_ready", {31'd0, req0_ready},
            {31'd0, g == 0});
        chk("req1_ready", {31'd0, req1_ready},
            {31'd0, g == 1});

        if (e_rsp) p_valid = 1'b0;

        if (g >= 0) begin
            p_valid = 1'b1;
            p_cyc   = cyc;
            p_owner = (g == 1);
            m_prio  = (g == 0);
            if (g == 0) begin
                p_wr = req0_wr; p_addr = req0_addr;
                p_data = req0_wr ? req0_wdata : ref_mem[req0_addr];
                void'(q0.pop_front());
            end else begin
                p_wr = req1_wr; p_addr = req1_addr;
                p_data = req1_wr ? req1_wdata : ref_mem[req1_addr];
                void'(q1.pop_front());
            end
            if (p_wr) ref_mem[p_addr] = p_data;
        end

        if (rst) begin
            p_valid      = 1'b0;
            m_prio       = PRIO_RESET;
            exp_rdata[0] = 8'h00;
            exp_rdata[1] = 8'h00;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        rst = (rst_cnt > 0)
              || (arm && p_valid && !p_wr && cyc == p_cyc + 2);
        if (rst_cnt > 0) rst_cnt--;
        if (arm && rst) arm = 1'b0;
        if (force_both) begin
            req0_valid = 1'b1; req1_valid = 1'b1;
            req0_wr = 1'b1; req1_wr = 1'b0;
            req0_addr = 3'($urandom); req1_addr = 3'($urandom);
            req0_wdata = 8'($urandom); req1_wdata = 8'($urandom);
        end else begin
            req0_valid = q0.size() > 0;
            req1_valid = q1.size() > 0;
            if (req0_valid) begin
                req0_wr = q0[0].wr; req0_addr = q0[0].addr;
                req0_wdata = q0[0].data;
            end
            if (req1_valid) begin
                req1_wr = q1[0].wr; req1_addr = q1[0].addr;
                req1_wdata = q1[0].data;
            end
        end
        @(negedge clk);
        model_check();
    endtask

    task automatic run_idle(input int budget);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || p_valid)
               && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) chk("timeout", 32'd1, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_wr = 1'b0; req1_wr = 1'b0;
        req0_addr = '0; req1_addr = '0;
        req0_wdata = '0; req1_wdata = '0;
        for (int i = 0; i < 8; i++) ref_mem[i] = 8'h00;
        exp_rdata[0] = 8'h00;
        exp_rdata[1] = 8'h00;
        m_prio  = PRIO_RESET;
        p_valid = 1'b0;
        p_cyc   = 0;
        p_owner = 1'b0;
        p_wr    = 1'b0;
        p_addr  = '0;
        p_data  = '0;
        arm     = 1'b0;

        // Reset with both requesters asserting valid.
        force_both = 1'b1;
        rst_cnt    = 2;
        step();
        step();
        force_both = 1'b0;

        // Give every SRAM word a known value.
        for (int i = 0; i < 8; i++)
            push(0, 1'b1, 3'(i), 8'($urandom));
        run_idle(200);

        // Write then read back from requester 0.
        push(0, 1'b1, 3'd5, 8'hA5);
        push(0, 1'b0, 3'd5, 8'h00);
        run_idle(50);

        // Contention every cycle: writes from 0, reads from 1.
        for (int i = 0; i < 8; i++) begin
            push(0, 1'b1, 3'(i), 8'($urandom));
            push(1, 1'b0, 3'(7 - i), 8'h00);
        end
        run_idle(200);

        // Requester 1 alone, requester 0 result must stay put.
        push(1, 1'b1, 3'd7, 8'h3C);
        push(1, 1'b0, 3'd7, 8'h00);
        run_idle(50);

        // Reset while a read sits in CAPTURE, then re-read.
        push(0, 1'b1, 3'd2, 8'h5A);
        run_idle(50);
        arm = 1'b1;
        push(0, 1'b0, 3'd2, 8'h00);
        run_idle(50);
        push(0, 1'b0, 3'd2, 8'h00);
        run_idle(50);

        // Back-to-back reads over the full address range.
        for (int i = 0; i < 8; i++)
            push(0, 1'b0, 3'(i), 8'h00);
        run_idle(200);

        // Random traffic from both requesters.
        for (int n = 0; n < 600; n++) begin
            if (q0.size() == 0 && $urandom_range(0, 2) == 0)
                push(0, 1'($urandom), 3'($urandom), 8'($urandom));
            if (q1.size() == 0 && $urandom_range(0, 2) == 0)
                push(1, 1'($urandom), 3'($urandom), 8'($urandom));
            step();
        end
        run_idle(200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
